uart_csr_bridge: RTL and testbench
==================================

UART_CSR_BRIDGE -- requirements
Module: uart_csr_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, CSR address width (1..8).
REQ-002 SHALL have parameter DATA_W, default 8, CSR data width (1..8).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000000, inter-byte timeout in clk cycles (>=2).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx_data  in  8  received byte from UART rx.
REQ-007 SHALL have port rx_flag  in  1  rx_data valid; held until cleared.
REQ-008 SHALL have port rx_flag_clr  out  1  one-cycle pulse consuming current rx byte.
REQ-009 SHALL have port tx_data  out  8  response byte to UART tx.
REQ-010 SHALL have port tx_send  out  1  one-cycle send request.
REQ-011 SHALL have port tx_data_ready  in  1  UART tx able to accept a byte.
REQ-012 SHALL have ports csr_wr_addr out ADDR_W, csr_wr_data out DATA_W, csr_wen out 1: CSR write request.
REQ-013 SHALL have ports csr_rd_addr out ADDR_W, csr_ren out 1, csr_rd_data in DATA_W: CSR read request/data.
REQ-014 SHALL have port busy  out  1  high whenever FSM is not IDLE.
REQ-015 SHALL have port cmd_error  out  1  one-cycle pulse on bad opcode or timeout.

Function
REQ-016 SHALL implement host-side CSR initiator: decodes byte frames from UART rx, issues CSR accesses, replies via UART tx.
REQ-017 SHALL accept frames: write = 0x57,addr,data; read = 0x52,addr; other first bytes = bad opcode.
REQ-018 SHALL accept a byte in cycle N when rx_flag=1, rx_flag_clr=0, state in {IDLE,GET_ADDR,GET_DATA}; rx_flag_clr registered, high in cycle N+1 only.
REQ-019 SHALL ignore rx_flag in any cycle where rx_flag_clr=1 (no double consumption).
REQ-020 SHALL use states IDLE, GET_ADDR, GET_DATA, CSR_WR, CSR_RD, RD_CAP, SEND.
REQ-021 SHALL transition IDLE->GET_ADDR on opcode 0x57/0x52 (opcode latched); bad opcode: stay IDLE, pulse cmd_error in N+1.
REQ-022 SHALL latch addr = rx_data[ADDR_W-1:0] in GET_ADDR; upper bits ignored; write->GET_DATA, read->CSR_RD.
REQ-023 SHALL latch data = rx_data[DATA_W-1:0] in GET_DATA, then ->CSR_WR.
REQ-024 SHALL in CSR_WR assert csr_wen for exactly one cycle with latched addr/data, set reply 0x4B, ->SEND.
REQ-025 SHALL in CSR_RD assert csr_ren one cycle with latched addr, ->RD_CAP; in RD_CAP capture csr_rd_data (one-cycle read latency), zero-extend to 8 bits as reply, ->SEND.
REQ-026 SHALL in SEND hold tx_data=reply; when tx_data_ready=1 pulse tx_send one cycle and ->IDLE; otherwise wait indefinitely, no timeout.
REQ-027 SHALL not consume rx bytes in CSR_WR, CSR_RD, RD_CAP, SEND; bytes arriving then remain pending in UART rx.
REQ-028 SHALL run a timeout counter in GET_ADDR/GET_DATA, cleared on entry and on each accepted byte; reaching TIMEOUT_CYC-1 -> IDLE, cmd_error pulse, no CSR access.
REQ-029 SHALL give byte acceptance priority over timeout expiry in the same cycle.
REQ-030 SHALL drive csr_wr_addr/csr_rd_addr/csr_wr_data from latched registers; values are don't-care while wen/ren low.

Reset
REQ-031 SHALL on rst_n=0 immediately go to IDLE and clear rx_flag_clr, tx_send, csr_wen, csr_ren, cmd_error, busy, tx_data, address/data/reply registers and timeout counter to 0.
REQ-032 SHALL abort any partial frame on reset mid-operation; no CSR access or tx_send after reset until a new complete frame.

Verification
REQ-033 Bytes 0x57,0x03,0xA5 -> single csr_wen pulse with addr=3, data=0xA5, then tx_send with tx_data=0x4B.
REQ-034 Bytes 0x52,0x02 with csr_rd_data=0x5C in RD_CAP -> csr_ren pulse addr=2, then tx_send with tx_data=0x5C.
REQ-035 Byte 0x41 -> rx_flag_clr pulse, cmd_error pulse, busy stays 0, no CSR access.
REQ-036 TIMEOUT_CYC=16, byte 0x57 then silence -> cmd_error after 16 cycles, IDLE, no csr_wen.
REQ-037 Read with tx_data_ready=0 for 50 cycles -> tx_send withheld, tx_data stable, sent on first ready cycle.
REQ-038 rst_n low after 0x57,0x01 -> all outputs 0; next 0x52,0x01 frame completes normally.

Source files
------------

// File: rtl/uart_csr_bridge.sv
// rtl/uart_csr_bridge.sv - UART byte-frame decoder that issues CSR writes/reads and replies over UART tx
module uart_csr_bridge #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_flag,
  output logic              rx_flag_clr,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_data_ready,
  output logic [ADDR_W-1:0] csr_wr_addr,
  output logic [DATA_W-1:0] csr_wr_data,
  output logic              csr_wen,
  output logic [ADDR_W-1:0] csr_rd_addr,
  output logic              csr_ren,
  input  logic [DATA_W-1:0] csr_rd_data,
  output logic              busy,
  output logic              cmd_error
);

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h4B;
  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, CSR_WR, CSR_RD, RD_CAP, SEND
  } state_t;

  state_t            state;
  logic              is_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [TMR_W-1:0]  tmr;
  logic              rx_take;

  // A byte whose clear pulse is still in flight must not be consumed twice.
  assign rx_take = rx_flag && !rx_flag_clr &&
                   (state == IDLE || state == GET_ADDR || state == GET_DATA);

  assign csr_wr_addr = addr_q;
  assign csr_rd_addr = addr_q;
  assign csr_wr_data = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      is_wr       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      tmr         <= '0;
      rx_flag_clr <= 1'b0;
      tx_data     <= 8'h00;
      tx_send     <= 1'b0;
      csr_wen     <= 1'b0;
      csr_ren     <= 1'b0;
      busy        <= 1'b0;
      cmd_error   <= 1'b0;
    end else begin
      rx_flag_clr <= rx_take;
      tx_send     <= 1'b0;
      csr_wen     <= 1'b0;
      csr_ren     <= 1'b0;
      cmd_error   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_take) begin
            if (rx_data == OP_WR || rx_data == OP_RD) begin
              is_wr <= (rx_data == OP_WR);
              tmr   <= '0;
              state <= GET_ADDR;
              busy  <= 1'b1;
            end else begin
              cmd_error <= 1'b1;
            end
          end
        end
        GET_ADDR: begin
          if (rx_take) begin
            addr_q <= rx_data[ADDR_W-1:0];
            tmr    <= '0;
            if (is_wr) begin
              state <= GET_DATA;
            end else begin
              state   <= CSR_RD;
              csr_ren <= 1'b1;
            end
          end else if (tmr == TMR_LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_error <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        GET_DATA: begin
          if (rx_take) begin
            data_q  <= rx_data[DATA_W-1:0];
            tmr     <= '0;
            state   <= CSR_WR;
            csr_wen <= 1'b1;
          end else if (tmr == TMR_LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_error <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        CSR_WR: begin
          tx_data <= ACK;
          state   <= SEND;
        end
        CSR_RD: begin
          state <= RD_CAP;
        end
        // Read data arrives one cycle after the csr_ren strobe.
        RD_CAP: begin
          tx_data <= 8'(csr_rd_data);
          state   <= SEND;
        end
        SEND: begin
          if (tx_data_ready) begin
            tx_send <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_csr_bridge.sv
// tb/tb_uart_csr_bridge.sv - self-checking bench for uart_csr_bridge
module tb_uart_csr_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       rx_flag_clr;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_data_ready;
  logic [3:0] csr_wr_addr;
  logic [7:0] csr_wr_data;
  logic       csr_wen;
  logic [3:0] csr_rd_addr;
  logic       csr_ren;
  logic [7:0] csr_rd_data;
  logic       busy;
  logic       cmd_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_csr_bridge #(.ADDR_W(4), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_flag(rx_flag),
    .rx_flag_clr(rx_flag_clr), .tx_data(tx_data), .tx_send(tx_send),
    .tx_data_ready(tx_data_ready), .csr_wr_addr(csr_wr_addr),
    .csr_wr_data(csr_wr_data), .csr_wen(csr_wen), .csr_rd_addr(csr_rd_addr),
    .csr_ren(csr_ren), .csr_rd_data(csr_rd_data), .busy(busy),
    .cmd_error(cmd_error)
  );

  function automatic logic [7:0] init_val(input logic [3:0] a);
    return {a, ~a} ^ 8'h36;
  endfunction

  // CSR target: one-cycle read latency, unwritten locations return init_val.
  logic [7:0]  slave_mem [16];
  logic [15:0] slave_wr = '0;
  always @(posedge clk) begin
    if (csr_wen) begin
      slave_mem[csr_wr_addr] <= csr_wr_data;
      slave_wr[csr_wr_addr]  <= 1'b1;
    end
    if (csr_ren)
      csr_rd_data <= slave_wr[csr_rd_addr] ? slave_mem[csr_rd_addr] : init_val(csr_rd_addr);
  end

  // Event logs, appended on every falling edge.
  int cyc = 0, wr_n = 0, rd_n = 0, tx_n = 0, err_n = 0, clr_n = 0, busy_n = 0;
  int last_clr_cyc = 0, last_err_cyc = 0;
  logic [3:0] wr_a_log [512];
  logic [7:0] wr_d_log [512];
  logic [3:0] rd_a_log [512];
  logic [7:0] tx_log   [512];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (csr_wen) begin
        wr_a_log[wr_n] <= csr_wr_addr;
        wr_d_log[wr_n] <= csr_wr_data;
        wr_n <= wr_n + 1;
      end
      if (csr_ren) begin
        rd_a_log[rd_n] <= csr_rd_addr;
        rd_n <= rd_n + 1;
      end
      if (tx_send) begin
        tx_log[tx_n] <= tx_data;
        tx_n <= tx_n + 1;
      end
      if (cmd_error) begin
        err_n <= err_n + 1;
        last_err_cyc <= cyc;
      end
      if (rx_flag_clr) begin
        clr_n <= clr_n + 1;
        last_clr_cyc <= cyc;
      end
      if (busy) busy_n <= busy_n + 1;
    end
  end

  // Reference model: CSR contents as the host expects them to be.
  logic [7:0] model_mem [16];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    tick();
    rx_data = b;
    rx_flag = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (rx_flag_clr) got = 1;
    end
    rx_flag = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rx_accept byte=%02h: rx_flag_clr seen=0 required=1", b);
    end
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [7:0] ab,
                           input logic [7:0] db, input int stall);
    int t0 = tx_n;
    if (stall > 0) tx_data_ready = 1'b0;
    send_byte(op);
    if (op == 8'h57 || op == 8'h52) begin
      send_byte(ab);
      if (op == 8'h57) send_byte(db);
      repeat (stall) tick();
      tx_data_ready = 1'b1;
      for (int i = 0; i < 50 && tx_n == t0; i++) tick();
    end else begin
      tx_data_ready = 1'b1;
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_flag_clr, tx_send, csr_wen, csr_ren, cmd_error, busy, tx_data} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got=%04h required=0000",
               {rx_flag_clr, tx_send, csr_wen, csr_ren, cmd_error, busy, tx_data});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, tx_data, csr_wr_addr, csr_wr_data} !== 21'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b tx_data=%02h addr=%0h data=%02h required all 0",
               busy, tx_data, csr_wr_addr, csr_wr_data);
    end
  endtask

  task automatic test_write();
    int w0 = wr_n, t0 = tx_n;
    run_frame(8'h57, 8'h03, 8'hA5, 0);
    model_mem[3] = 8'hA5;
    checks++;
    if (wr_n - w0 !== 1) begin errors++; $display("FAIL write_wen_count: got=%0d required=1", wr_n - w0); end
    checks++;
    if (wr_a_log[w0] !== 4'h3 || wr_d_log[w0] !== 8'hA5) begin
      errors++;
      $display("FAIL write_addr_data: got=%0h/%02h required=3/a5", wr_a_log[w0], wr_d_log[w0]);
    end
    checks++;
    if (tx_n - t0 !== 1 || tx_log[t0] !== 8'h4B) begin
      errors++;
      $display("FAIL write_reply: count=%0d byte=%02h required=1/4b", tx_n - t0, tx_log[t0]);
    end
  endtask

  task automatic test_read();
    int r0, t0, w0;
    run_frame(8'h57, 8'h02, 8'h5C, 0);
    model_mem[2] = 8'h5C;
    r0 = rd_n; t0 = tx_n; w0 = wr_n;
    run_frame(8'h52, 8'h02, 8'h00, 0);
    checks++;
    if (rd_n - r0 !== 1 || rd_a_log[r0] !== 4'h2) begin
      errors++;
      $display("FAIL read_ren: count=%0d addr=%0h required=1/2", rd_n - r0, rd_a_log[r0]);
    end
    checks++;
    if (tx_n - t0 !== 1 || tx_log[t0] !== model_mem[2]) begin
      errors++;
      $display("FAIL read_reply: count=%0d byte=%02h required=1/%02h", tx_n - t0, tx_log[t0], model_mem[2]);
    end
    checks++;
    if (wr_n !== w0) begin errors++; $display("FAIL read_no_write: wen pulses=%0d required=0", wr_n - w0); end
  endtask

  task automatic test_bad_opcode();
    int c0 = clr_n, e0 = err_n, b0 = busy_n, w0 = wr_n, r0 = rd_n, t0 = tx_n;
    run_frame(8'h41, 8'h00, 8'h00, 0);
    repeat (3) tick();
    checks++;
    if (clr_n - c0 !== 1 || err_n - e0 !== 1) begin
      errors++;
      $display("FAIL bad_op_pulses: clr=%0d err=%0d required=1/1", clr_n - c0, err_n - e0);
    end
    checks++;
    if (busy_n !== b0) begin errors++; $display("FAIL bad_op_busy: busy cycles=%0d required=0", busy_n - b0); end
    checks++;
    if (wr_n !== w0 || rd_n !== r0 || tx_n !== t0) begin
      errors++;
      $display("FAIL bad_op_access: wr=%0d rd=%0d tx=%0d required=0/0/0", wr_n - w0, rd_n - r0, tx_n - t0);
    end
  endtask

  task automatic test_timeout();
    int e0 = err_n, w0 = wr_n;
    send_byte(8'h57);
    repeat (22) tick();
    checks++;
    if (err_n - e0 !== 1) begin errors++; $display("FAIL timeout_err_count: got=%0d required=1", err_n - e0); end
    checks++;
    if (last_err_cyc - last_clr_cyc !== 16) begin
      errors++;
      $display("FAIL timeout_latency: got=%0d required=16", last_err_cyc - last_clr_cyc);
    end
    checks++;
    if (wr_n !== w0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: wen=%0d busy=%0b required=0/0", wr_n - w0, busy);
    end
  endtask

  task automatic test_tx_stall();
    int t0 = tx_n;
    logic [7:0] held;
    bit stable = 1;
    tx_data_ready = 1'b0;
    send_byte(8'h52);
    send_byte(8'h07);
    repeat (4) tick();
    held = tx_data;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_data !== held) stable = 0;
    end
    checks++;
    if (tx_n !== t0) begin errors++; $display("FAIL stall_withheld: tx_send pulses=%0d required=0", tx_n - t0); end
    checks++;
    if (!stable || held !== model_mem[7]) begin
      errors++;
      $display("FAIL stall_tx_data: stable=%0b byte=%02h required=1/%02h", stable, held, model_mem[7]);
    end
    tx_data_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (tx_n - t0 !== 1 || tx_log[t0] !== model_mem[7]) begin
      errors++;
      $display("FAIL stall_release: count=%0d byte=%02h required=1/%02h", tx_n - t0, tx_log[t0], model_mem[7]);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_n, t0, r0;
    send_byte(8'h57);
    send_byte(8'h01);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_flag_clr, tx_send, csr_wen, csr_ren, cmd_error, busy, tx_data, csr_wr_addr, csr_wr_data} !== 26'd0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%0b tx_data=%02h addr=%0h required all 0", busy, tx_data, csr_wr_addr);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    checks++;
    if (wr_n !== w0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort: wen=%0d busy=%0b required=0/0", wr_n - w0, busy);
    end
    r0 = rd_n; t0 = tx_n;
    run_frame(8'h52, 8'h01, 8'h00, 0);
    checks++;
    if (rd_n - r0 !== 1 || rd_a_log[r0] !== 4'h1 || tx_log[t0] !== model_mem[1]) begin
      errors++;
      $display("FAIL midreset_next_frame: rd=%0d addr=%0h byte=%02h required=1/1/%02h",
               rd_n - r0, rd_a_log[r0], tx_log[t0], model_mem[1]);
    end
  endtask

  task automatic test_back_to_back();
    int c0, t0 = tx_n, w0 = wr_n;
    bit got = 0;
    tx_data_ready = 1'b0;
    send_byte(8'h52);
    send_byte(8'h05);
    repeat (4) tick();
    c0 = clr_n;
    rx_data = 8'h57;
    rx_flag = 1'b1;
    repeat (10) tick();
    checks++;
    if (clr_n !== c0) begin errors++; $display("FAIL pending_held: clr pulses=%0d required=0", clr_n - c0); end
    tx_data_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (rx_flag_clr) got = 1;
    end
    rx_flag = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL pending_accept: clr seen=0 required=1"); end
    send_byte(8'h0C);
    send_byte(8'h99);
    for (int i = 0; i < 50 && tx_n - t0 < 2; i++) tick();
    tick();
    model_mem[12] = 8'h99;
    checks++;
    if (tx_n - t0 !== 2 || tx_log[t0] !== model_mem[5] || tx_log[t0+1] !== 8'h4B) begin
      errors++;
      $display("FAIL b2b_replies: count=%0d bytes=%02h,%02h required=2/%02h,4b",
               tx_n - t0, tx_log[t0], tx_log[t0+1], model_mem[5]);
    end
    checks++;
    if (wr_n - w0 !== 1 || wr_a_log[w0] !== 4'hC || wr_d_log[w0] !== 8'h99) begin
      errors++;
      $display("FAIL b2b_write: count=%0d addr=%0h data=%02h required=1/c/99",
               wr_n - w0, wr_a_log[w0], wr_d_log[w0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int kind = $urandom_range(0, 4);
      int stall = $urandom_range(0, 6);
      logic [7:0] ab = 8'($urandom);
      logic [7:0] db = 8'($urandom);
      logic [7:0] op;
      logic [3:0] a;
      int w0 = wr_n, r0 = rd_n, t0 = tx_n, e0 = err_n;
      a = ab[3:0];
      if (kind < 2) op = 8'h57;
      else if (kind < 4) op = 8'h52;
      else begin
        op = 8'($urandom);
        if (op == 8'h57 || op == 8'h52) op = 8'h00;
      end
      run_frame(op, ab, db, stall);
      checks++;
      if (op == 8'h57) begin
        if (wr_n - w0 !== 1 || wr_a_log[w0] !== a || wr_d_log[w0] !== db || tx_log[t0] !== 8'h4B) begin
          errors++;
          $display("FAIL rand_write[%0d]: n=%0d addr=%0h data=%02h reply=%02h required=1/%0h/%02h/4b",
                   n, wr_n - w0, wr_a_log[w0], wr_d_log[w0], tx_log[t0], a, db);
        end
        model_mem[a] = db;
      end else if (op == 8'h52) begin
        if (rd_n - r0 !== 1 || rd_a_log[r0] !== a || tx_n - t0 !== 1 || tx_log[t0] !== model_mem[a]) begin
          errors++;
          $display("FAIL rand_read[%0d]: n=%0d addr=%0h reply=%02h required=1/%0h/%02h",
                   n, rd_n - r0, rd_a_log[r0], tx_log[t0], a, model_mem[a]);
        end
      end else begin
        if (err_n - e0 !== 1 || tx_n !== t0 || wr_n !== w0 || rd_n !== r0) begin
          errors++;
          $display("FAIL rand_badop[%0d] op=%02h: err=%0d tx=%0d required=1/0", n, op, err_n - e0, tx_n - t0);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_flag = 1'b0;
    tx_data_ready = 1'b1;
    for (int i = 0; i < 16; i++) model_mem[i] = init_val(4'(i));
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_timeout();
    test_tx_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
